// File: rtl/flit_injector_if.sv
`timescale 1ns/1ps
// Packet-descriptor handshake from the traffic source into the flit injector.
// master = traffic source, slave = injector; a descriptor moves on pkt_valid && pkt_ready.
interface flit_injector_if #(
  parameter int VC_W  = 2,
  parameter int DST_W = 14,
  parameter int LEN_W = 4,
  parameter int CYC_W = 20
);
  logic             pkt_valid;
  logic             pkt_ready;
  logic [DST_W-1:0] pkt_dst;
  logic [VC_W-1:0]  pkt_vc;
  logic [LEN_W-1:0] pkt_len;
  logic [CYC_W-1:0] pkt_time;

  modport master (
    output pkt_valid, pkt_dst, pkt_vc, pkt_len, pkt_time,
    input  pkt_ready
  );

  modport slave (
    input  pkt_valid, pkt_dst, pkt_vc, pkt_len, pkt_time,
    output pkt_ready
  );
endinterface

// File: rtl/flit_injector.sv
`timescale 1ns/1ps
// Queues packet descriptors and segments them into head/body/tail flits for router port 0.
// One flit per inj_slot at most; stalls on can_inject[vc] or timestamp, pkt_ready drops when the queue is full.
module flit_injector #(
  parameter int NVC       = 4,
  parameter int VC_W      = 2,
  parameter int DST_W     = 14,
  parameter int LEN_W     = 4,
  parameter int CYC_W     = 20,
  parameter int PKT_DEPTH = 8,
  parameter int FLIT_W    = 1 + VC_W + 2 + DST_W
) (
  input  logic              clk,
  input  logic              rst,
  flit_injector_if.slave    pkt,
  input  logic [CYC_W-1:0]  in_cycle,
  input  logic              inj_slot,
  input  logic [NVC-1:0]    can_inject,
  output logic [FLIT_W-1:0] out_staging,
  output logic              idle,
  output logic [15:0]       pkts_sent
);

  localparam int AW = $clog2(PKT_DEPTH);
  localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);

  typedef struct packed {
    logic [DST_W-1:0] dst;
    logic [VC_W-1:0]  vc;
    logic [LEN_W-1:0] len;
    logic [CYC_W-1:0] tstamp;
  } desc_t;

  typedef enum logic [1:0] {IDLE, HEAD, BODY} state_t;

  desc_t            fifo_mem [PKT_DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             fifo_full;
  logic             fifo_empty;
  logic             push;
  desc_t            push_desc;
  desc_t            head_desc;

  state_t           state_q;
  state_t           state_d;
  logic [DST_W-1:0] cur_dst;
  logic [VC_W-1:0]  cur_vc;
  logic [LEN_W-1:0] cur_rem;
  logic [CYC_W-1:0] cur_time;
  logic             pop;
  logic             emit;
  logic             is_tail;
  logic [FLIT_W-1:0] flit_d;

  // Extra MSB on each pointer separates full from empty when the index bits match.
  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pkt.pkt_ready = ~fifo_full;
  assign push       = pkt.pkt_valid && ~fifo_full;
  assign push_desc  = '{dst: pkt.pkt_dst, vc: pkt.pkt_vc, len: pkt.pkt_len, tstamp: pkt.pkt_time};
  assign head_desc  = fifo_mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr[AW-1:0]] <= push_desc;
    end
  end

  assign is_tail = (cur_rem == LEN_ONE);
  assign flit_d  = {1'b1, cur_vc, (state_q == HEAD), is_tail, cur_dst};

  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    emit    = 1'b0;
    case (state_q)
      IDLE: begin
        if (inj_slot && !fifo_empty) begin
          pop     = 1'b1;
          state_d = HEAD;
        end
      end
      HEAD: begin
        // The timestamp gates only the head; body flits follow as soon as the VC frees up.
        if (inj_slot && (in_cycle >= cur_time) && can_inject[cur_vc]) begin
          emit    = 1'b1;
          state_d = is_tail ? IDLE : BODY;
        end
      end
      BODY: begin
        if (inj_slot && can_inject[cur_vc]) begin
          emit    = 1'b1;
          state_d = is_tail ? IDLE : BODY;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      cur_dst     <= '0;
      cur_vc      <= '0;
      cur_rem     <= '0;
      cur_time    <= '0;
      out_staging <= '0;
      pkts_sent   <= '0;
    end else begin
      state_q <= state_d;
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr   <= rd_ptr + 1'b1;
        cur_dst  <= head_desc.dst;
        cur_vc   <= head_desc.vc;
        cur_rem  <= (head_desc.len == '0) ? LEN_ONE : head_desc.len;
        cur_time <= head_desc.tstamp;
      end
      if (emit) begin
        cur_rem <= cur_rem - LEN_ONE;
      end
      if (inj_slot) begin
        out_staging <= emit ? flit_d : '0;
      end
      if (emit && is_tail && (pkts_sent != 16'hFFFF)) begin
        pkts_sent <= pkts_sent + 16'd1;
      end
    end
  end

  assign idle = fifo_empty && (state_q == IDLE) && !out_staging[FLIT_W-1];

endmodule

// File: tb/tb_flit_injector.sv
`timescale 1ns/1ps
// Directed bench for flit_injector: segmentation, backpressure, timestamp gating, FIFO limits, reset.
module tb_flit_injector;

  localparam int NVC       = 4;
  localparam int VC_W      = 2;
  localparam int DST_W     = 14;
  localparam int LEN_W     = 4;
  localparam int CYC_W     = 20;
  localparam int PKT_DEPTH = 8;
  localparam int FLIT_W    = 1 + VC_W + 2 + DST_W;

  logic              clk = 1'b0;
  logic              rst;
  logic [CYC_W-1:0]  in_cycle;
  logic              inj_slot;
  logic [NVC-1:0]    can_inject;
  logic [FLIT_W-1:0] out_staging;
  logic              idle;
  logic [15:0]       pkts_sent;

  int n_chk = 0;
  int n_bad = 0;

  flit_injector_if #(.VC_W(VC_W), .DST_W(DST_W), .LEN_W(LEN_W), .CYC_W(CYC_W)) pif ();

  flit_injector #(
    .NVC(NVC), .VC_W(VC_W), .DST_W(DST_W), .LEN_W(LEN_W),
    .CYC_W(CYC_W), .PKT_DEPTH(PKT_DEPTH), .FLIT_W(FLIT_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .pkt         (pif.slave),
    .in_cycle    (in_cycle),
    .inj_slot    (inj_slot),
    .can_inject  (can_inject),
    .out_staging (out_staging),
    .idle        (idle),
    .pkts_sent   (pkts_sent)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mk(input logic [VC_W-1:0] vc, input logic h, input logic t,
                                     input logic [DST_W-1:0] d);
    logic [FLIT_W-1:0] f;
    f = {1'b1, vc, h, t, d};
    return 32'(f);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [DST_W-1:0] d, input logic [VC_W-1:0] vc,
                      input logic [LEN_W-1:0] len, input logic [CYC_W-1:0] t);
    pif.pkt_valid = 1'b1;
    pif.pkt_dst   = d;
    pif.pkt_vc    = vc;
    pif.pkt_len   = len;
    pif.pkt_time  = t;
    tick();
    pif.pkt_valid = 1'b0;
  endtask

  task automatic slot();
    inj_slot = 1'b1;
    tick();
    inj_slot = 1'b0;
  endtask

  initial begin
    rst           = 1'b1;
    in_cycle      = '0;
    inj_slot      = 1'b0;
    can_inject    = 4'hF;
    pif.pkt_valid = 1'b0;
    pif.pkt_dst   = '0;
    pif.pkt_vc    = '0;
    pif.pkt_len   = '0;
    pif.pkt_time  = '0;
    tick();
    tick();
    rst = 1'b0;
    check("rst_out",   32'(out_staging), 0);
    check("rst_rdy",   32'(pif.pkt_ready), 1);
    check("rst_idle",  32'(idle), 1);
    check("rst_cnt",   32'(pkts_sent), 0);

    // T1 single flit
    push(14'd12, 2'd1, 4'd1, 20'd0);
    check("t1_busy", 32'(idle), 0);
    slot();
    check("t1_pop_out", 32'(out_staging), 0);
    slot();
    check("t1_flit", 32'(out_staging), 32'h5C00C);
    check("t1_flit_mk", 32'(out_staging), mk(2'd1, 1'b1, 1'b1, 14'd12));
    slot();
    check("t1_after", 32'(out_staging), 0);
    check("t1_idle",  32'(idle), 1);
    check("t1_cnt",   32'(pkts_sent), 1);

    // T2 three-flit packet
    push(14'd5, 2'd2, 4'd3, 20'd0);
    slot();
    slot();
    check("t2_head", 32'(out_staging), mk(2'd2, 1'b1, 1'b0, 14'd5));
    slot();
    check("t2_body", 32'(out_staging), mk(2'd2, 1'b0, 1'b0, 14'd5));
    slot();
    check("t2_tail", 32'(out_staging), mk(2'd2, 1'b0, 1'b1, 14'd5));
    slot();
    check("t2_after", 32'(out_staging), 0);
    check("t2_cnt",   32'(pkts_sent), 2);

    // T3 backpressure on VC2 mid-packet
    push(14'd5, 2'd2, 4'd3, 20'd0);
    slot();
    slot();
    check("t3_head", 32'(out_staging), mk(2'd2, 1'b1, 1'b0, 14'd5));
    can_inject = 4'hB;
    slot();
    check("t3_stall0", 32'(out_staging), 0);
    slot();
    check("t3_stall1", 32'(out_staging), 0);
    can_inject = 4'hF;
    slot();
    check("t3_body", 32'(out_staging), mk(2'd2, 1'b0, 1'b0, 14'd5));
    slot();
    check("t3_tail", 32'(out_staging), mk(2'd2, 1'b0, 1'b1, 14'd5));
    slot();
    check("t3_after", 32'(out_staging), 0);
    check("t3_cnt",   32'(pkts_sent), 3);

    // T4 timestamp gating of the head flit
    push(14'd7, 2'd0, 4'd1, 20'd100);
    in_cycle = 20'd96;
    slot();
    for (int c = 97; c < 100; c++) begin
      in_cycle = 20'(c);
      slot();
      check("t4_hold", 32'(out_staging), 0);
    end
    in_cycle = 20'd100;
    slot();
    check("t4_head", 32'(out_staging), mk(2'd0, 1'b1, 1'b1, 14'd7));
    tick();
    check("t4_stable", 32'(out_staging), mk(2'd0, 1'b1, 1'b1, 14'd7));
    slot();
    check("t4_after", 32'(out_staging), 0);
    check("t4_cnt",   32'(pkts_sent), 4);
    in_cycle = '0;

    // T5 FIFO full, refused push, simultaneous push/pop, pointer wrap
    for (int i = 0; i < 8; i++) begin
      check("t5_rdy_fill", 32'(pif.pkt_ready), 1);
      push(14'(20 + i), 2'd3, 4'd1, 20'd0);
    end
    check("t5_full", 32'(pif.pkt_ready), 0);
    push(14'd99, 2'd3, 4'd1, 20'd0);
    slot();
    check("t5_rdy_pop", 32'(pif.pkt_ready), 1);
    slot();
    check("t5_p20", 32'(out_staging), mk(2'd3, 1'b1, 1'b1, 14'd20));
    pif.pkt_valid = 1'b1;
    pif.pkt_dst   = 14'd28;
    pif.pkt_vc    = 2'd3;
    pif.pkt_len   = 4'd1;
    pif.pkt_time  = 20'd0;
    inj_slot      = 1'b1;
    tick();
    pif.pkt_valid = 1'b0;
    inj_slot      = 1'b0;
    check("t5_pp_out", 32'(out_staging), 0);
    check("t5_pp_rdy", 32'(pif.pkt_ready), 1);
    push(14'd29, 2'd3, 4'd1, 20'd0);
    check("t5_refull", 32'(pif.pkt_ready), 0);
    slot();
    check("t5_p21", 32'(out_staging), mk(2'd3, 1'b1, 1'b1, 14'd21));
    for (int k = 0; k < 8; k++) begin
      slot();
      slot();
      check("t5_drain", 32'(out_staging), mk(2'd3, 1'b1, 1'b1, 14'(22 + k)));
    end
    slot();
    check("t5_idle", 32'(idle), 1);
    check("t5_cnt",  32'(pkts_sent), 14);

    // T6 reset during body drops current and queued packets
    push(14'd9, 2'd1, 4'd4, 20'd0);
    slot();
    slot();
    check("t6_head", 32'(out_staging), mk(2'd1, 1'b1, 1'b0, 14'd9));
    slot();
    check("t6_body", 32'(out_staging), mk(2'd1, 1'b0, 1'b0, 14'd9));
    push(14'd10, 2'd0, 4'd1, 20'd0);
    rst      = 1'b1;
    inj_slot = 1'b1;
    tick();
    rst      = 1'b0;
    inj_slot = 1'b0;
    check("t6_out",  32'(out_staging), 0);
    check("t6_idle", 32'(idle), 1);
    check("t6_cnt",  32'(pkts_sent), 0);
    check("t6_rdy",  32'(pif.pkt_ready), 1);
    push(14'd11, 2'd2, 4'd0, 20'd0);
    slot();
    slot();
    check("t6_new_head", 32'(out_staging), mk(2'd2, 1'b1, 1'b1, 14'd11));
    slot();
    check("t6_new_after", 32'(out_staging), 0);
    check("t6_new_cnt",   32'(pkts_sent), 1);
    check("t6_new_idle",  32'(idle), 1);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
